// File: rtl/vrf_pkg.sv
// Shared types and write-enable helper for the masked vector register file.
// Lane count is capped at MAX_LANES by the helper's working width.
package vrf_pkg;

  localparam int MAX_LANES = 256;

  typedef enum logic [1:0] {
    WM_VEC,
    WM_BCAST,
    WM_LANE,
    WM_RSVD
  } wmode_e;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } vrf_state_e;

  // Per-lane write enables; a lane index beyond the vector writes nothing.
  function automatic logic [MAX_LANES-1:0] lane_we(
    input wmode_e                mode,
    input logic [MAX_LANES-1:0]  mask,
    input logic [7:0]            lane,
    input int                    lanes
  );
    logic [MAX_LANES-1:0] r;
    r = '0;
    unique case (mode)
      WM_VEC, WM_BCAST: r = mask;
      WM_LANE: begin
        if (int'(lane) < lanes) r[lane] = mask[lane];
      end
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/vector_regfile_masked_read.sv
// One read port: zero-register and busy gating.
// Same-cycle write forwarding is built only with VRF_WRITE_BYPASS_EN.
module vrf_read_port #(
  parameter int WIDTH       = 16,
  parameter int VECTOR_SIZE = 16,
  parameter int IDX_W       = 4
) (
`ifdef VRF_WRITE_BYPASS_EN
  input  logic [VECTOR_SIZE-1:0]       wen,
  input  logic [IDX_W-1:0]             wr_idx,
  input  logic [VECTOR_SIZE*WIDTH-1:0] wdata,
`endif
  input  logic [IDX_W-1:0]             idx,
  input  logic                         busy,
  input  logic [VECTOR_SIZE*WIDTH-1:0] stored,
  output logic [VECTOR_SIZE*WIDTH-1:0] rd
);
  import vrf_pkg::*;

  always_comb begin
    rd = stored;
`ifdef VRF_WRITE_BYPASS_EN
    for (int i = 0; i < VECTOR_SIZE; i++) begin
      if (wen[i] && (idx == wr_idx))
        rd[i*WIDTH +: WIDTH] = wdata[i*WIDTH +: WIDTH];
    end
`endif
    if (busy || (idx == '0)) rd = '0;
  end

endmodule

// File: rtl/vector_regfile_masked.sv
// Masked vector register file: 2 comb reads, 1 masked write, clear sweep.
// Optional same-cycle read forwarding: define VRF_WRITE_BYPASS_EN.
module vector_regfile_masked #(
  parameter int WIDTH        = 16,
  parameter int VECTOR_SIZE  = 16,
  parameter int NUM_VECTORES = 16,
  localparam int IDX_W  = $clog2(NUM_VECTORES),
  localparam int LANE_W = $clog2(VECTOR_SIZE)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr_req,
  output logic                         busy,
  input  logic                         we3,
  input  logic [1:0]                   wmode,
  input  logic [VECTOR_SIZE-1:0]       wmask,
  input  logic [LANE_W-1:0]            wlane,
  input  logic [IDX_W-1:0]             v1,
  input  logic [IDX_W-1:0]             v2,
  input  logic [IDX_W-1:0]             v3,
  input  logic [WIDTH-1:0]             wd3,
  input  logic [VECTOR_SIZE*WIDTH-1:0] wvec,
  output logic [VECTOR_SIZE*WIDTH-1:0] vd1,
  output logic [VECTOR_SIZE*WIDTH-1:0] vd2
);
  import vrf_pkg::*;

  localparam int VW = VECTOR_SIZE * WIDTH;

  logic [VW-1:0]          regs [NUM_VECTORES];
  vrf_state_e             state;
  logic [IDX_W-1:0]       clr_ptr;
  logic                   wr_act;
  logic [VECTOR_SIZE-1:0] wen;
  logic [VW-1:0]          wdata;

  assign busy   = (state == ST_CLEAR);
  assign wr_act = we3 && !busy && (v3 != '0);

  assign wen = wr_act
    ? VECTOR_SIZE'(lane_we(wmode_e'(wmode),
                           MAX_LANES'(wmask),
                           8'(wlane),
                           VECTOR_SIZE))
    : '0;

  assign wdata = (wmode_e'(wmode) == WM_VEC)
    ? wvec : {VECTOR_SIZE{wd3}};

  // A write and a clear request in the same idle cycle both take effect;
  // the sweep then zeroes what was just written.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_CLEAR;
      clr_ptr <= IDX_W'(1);
    end else if (state == ST_CLEAR) begin
      regs[clr_ptr] <= '0;
      clr_ptr       <= clr_ptr + IDX_W'(1);
      if (clr_ptr == IDX_W'(NUM_VECTORES-1))
        state <= ST_IDLE;
    end else begin
      for (int i = 0; i < VECTOR_SIZE; i++) begin
        if (wen[i])
          regs[v3][i*WIDTH +: WIDTH] <= wdata[i*WIDTH +: WIDTH];
      end
      if (clr_req) begin
        state   <= ST_CLEAR;
        clr_ptr <= IDX_W'(1);
      end
    end
  end

  vrf_read_port #(
    .WIDTH       (WIDTH),
    .VECTOR_SIZE (VECTOR_SIZE),
    .IDX_W       (IDX_W)
  ) u_rd1 (
`ifdef VRF_WRITE_BYPASS_EN
    .wen    (wen),
    .wr_idx (v3),
    .wdata  (wdata),
`endif
    .idx    (v1),
    .busy   (busy),
    .stored (regs[v1]),
    .rd     (vd1)
  );

  vrf_read_port #(
    .WIDTH       (WIDTH),
    .VECTOR_SIZE (VECTOR_SIZE),
    .IDX_W       (IDX_W)
  ) u_rd2 (
`ifdef VRF_WRITE_BYPASS_EN
    .wen    (wen),
    .wr_idx (v3),
    .wdata  (wdata),
`endif
    .idx    (v2),
    .busy   (busy),
    .stored (regs[v2]),
    .rd     (vd2)
  );

endmodule

// File: tb/tb_vector_regfile_masked.sv
// Bench for vector_regfile_masked: directed plan plus random traffic
// against an array model of the register file and a clear countdown.
module tb_vector_regfile_masked;

  localparam int W  = 16;
  localparam int VS = 16;
  localparam int NV = 16;
  localparam int VW = VS * W;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clr_req = 1'b0;
  logic          busy;
  logic          we3 = 1'b0;
  logic [1:0]    wmode = 2'd0;
  logic [VS-1:0] wmask = '0;
  logic [3:0]    wlane = '0;
  logic [3:0]    v1 = '0;
  logic [3:0]    v2 = '0;
  logic [3:0]    v3 = '0;
  logic [W-1:0]  wd3 = '0;
  logic [VW-1:0] wvec = '0;
  logic [VW-1:0] vd1;
  logic [VW-1:0] vd2;

  vector_regfile_masked dut (
    .clk     (clk),
    .rst     (rst),
    .clr_req (clr_req),
    .busy    (busy),
    .we3     (we3),
    .wmode   (wmode),
    .wmask   (wmask),
    .wlane   (wlane),
    .v1      (v1),
    .v2      (v2),
    .v3      (v3),
    .wd3     (wd3),
    .wvec    (wvec),
    .vd1     (vd1),
    .vd2     (vd2)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [VW-1:0] got,
                     input logic [VW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Model: register contents plus the number of sweep cycles left.
  logic [W-1:0] m_mem [NV][VS];
  int  left  = 0;
  bit  known = 0;

  function automatic bit lane_written(input int i);
    if (wmask[i] !== 1'b1) return 0;
    case (wmode)
      2'd0, 2'd1: return 1;
      2'd2:       return int'(wlane) == i;
      default:    return 0;
    endcase
  endfunction

  function automatic logic [W-1:0] new_val(input int i);
    return (wmode == 2'd0) ? wvec[i*W +: W] : wd3;
  endfunction

  function automatic logic [VW-1:0] exp_rd(input int idx);
    logic [VW-1:0] r;
    if (left > 0 || idx == 0) return '0;
    for (int i = 0; i < VS; i++) r[i*W +: W] = m_mem[idx][i];
`ifdef VRF_WRITE_BYPASS_EN
    if (we3 && v3 != 0 && int'(v3) == idx)
      for (int i = 0; i < VS; i++)
        if (lane_written(i)) r[i*W +: W] = new_val(i);
`endif
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      left  = NV - 1;
      known = 1;
    end else if (left > 0) begin
      for (int i = 0; i < VS; i++) m_mem[NV-left][i] = '0;
      left--;
    end else begin
      if (we3 && v3 != 0)
        for (int i = 0; i < VS; i++)
          if (lane_written(i)) m_mem[v3][i] = new_val(i);
      if (clr_req) left = NV - 1;
    end
  end

  always @(negedge clk) begin
    if (known) begin
      chk("busy", VW'(busy), VW'(left > 0));
      chk("vd1", vd1, exp_rd(int'(v1)));
      chk("vd2", vd2, exp_rd(int'(v2)));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; clr_req = 0; we3 = 0;
    wmode = 0; wmask = '0; wlane = '0;
    v3 = '0; wd3 = '0; wvec = '0;
  endtask

  task automatic busy_len(input string nm);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      step();
    end
    chk(nm, VW'(n), VW'(15));
  endtask

  logic [VW-1:0] e;

  initial begin
    for (int r = 0; r < NV; r++)
      for (int i = 0; i < VS; i++) m_mem[r][i] = '0;
    idle();
    step();
    rst = 1;
    step();
    rst = 0;
    busy_len("rst_busy_len");
    v1 = 4'd5; #1;
    chk("clear_v5", vd1, '0);

    // full-vector masked write
    we3 = 1; wmode = 0; v3 = 4'd3; wmask = 16'h00FF;
    for (int i = 0; i < VS; i++) wvec[i*W +: W] = W'(16'h100 + i);
    step();
    idle(); v1 = 4'd3; #1;
    for (int i = 0; i < VS; i++)
      e[i*W +: W] = (i < 8) ? W'(16'h100 + i) : '0;
    chk("vec_mask", vd1, e);

    // broadcast then single lane
    we3 = 1; wmode = 1; v3 = 4'd4; wd3 = 16'hABCD; wmask = 16'hFFFF;
    step();
    wmode = 2; wlane = 4'd7; wd3 = 16'h1234;
    step();
    idle(); v2 = 4'd4; #1;
    for (int i = 0; i < VS; i++)
      e[i*W +: W] = (i == 7) ? 16'h1234 : 16'hABCD;
    chk("bcast_lane", vd2, e);

    // zero register and reserved mode
    we3 = 1; wmode = 1; v3 = 4'd0; wd3 = 16'hFFFF; wmask = 16'hFFFF;
    step();
    wmode = 3; v3 = 4'd6;
    step();
    idle(); v1 = 4'd0; v2 = 4'd6; #1;
    chk("reg0_zero", vd1, '0);
    chk("rsvd_nowrite", vd2, '0);

    // write racing a clear request
    we3 = 1; wmode = 1; v3 = 4'd2; wd3 = 16'h5555;
    wmask = 16'hFFFF; clr_req = 1;
    step();
    idle(); v1 = 4'd2;
    busy_len("race_busy_len");
    chk("race_v2_zero", vd1, '0);

    // reset in the middle of a sweep restarts it
    clr_req = 1;
    step();
    clr_req = 0;
    repeat (4) step();
    rst = 1;
    step();
    rst = 0;
    busy_len("midrst_busy_len");

    // same-cycle forwarding on a single lane
    we3 = 1; wmode = 1; v3 = 4'd9; wd3 = 16'h1111; wmask = 16'hFFFF;
    step();
    wd3 = 16'hBEEF; wmask = 16'h0001; v1 = 4'd9; #1;
`ifdef VRF_WRITE_BYPASS_EN
    chk("bypass_same", VW'(vd1[W-1:0]), VW'(16'hBEEF));
`else
    chk("nobypass_same", VW'(vd1[W-1:0]), VW'(16'h1111));
`endif
    chk("bypass_lane1", VW'(vd1[2*W-1:W]), VW'(16'h1111));
    step();
    idle(); #1;
    chk("bypass_after", VW'(vd1[W-1:0]), VW'(16'hBEEF));

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      rst     = ($urandom % 400) == 0;
      clr_req = ($urandom % 60) == 0;
      we3     = ($urandom % 4) != 0;
      wmode   = 2'($urandom);
      case ($urandom % 4)
        0:       wmask = '0;
        1:       wmask = '1;
        default: wmask = VS'($urandom);
      endcase
      wlane = 4'($urandom);
      v3    = 4'($urandom);
      v1    = ($urandom % 3 == 0) ? v3 : 4'($urandom);
      v2    = ($urandom % 3 == 0) ? v3 : 4'($urandom);
      wd3   = W'($urandom);
      for (int k = 0; k < VW / 32; k++) wvec[k*32 +: 32] = $urandom;
      step();
    end
    idle();
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vector_regfile_masked.md
Name: vector_regfile_masked

Overview:
Next-generation vector register file for the vector datapath. It provides two combinational read ports and one synchronous write port. Writes support three modes: full-vector, scalar broadcast and single-lane, all under a per-lane write mask. A sequential clear engine zeroes the file after reset or on request, and a busy flag tells the decode stage when the file is unavailable. Register 0 is hardwired to zero.

Parameters:
WIDTH, 16, bits per element
VECTOR_SIZE, 16, elements (lanes) per vector register
NUM_VECTORES, 16, number of vector registers; minimum 2
IDX_W, $clog2(NUM_VECTORES), register index width (derived, localparam)
LANE_W, $clog2(VECTOR_SIZE), lane index width (derived, localparam)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
clr_req  in  1  request a full clear sweep
busy  out  1  clear sweep in progress; writes ignored
we3  in  1  write enable
wmode  in  2  0=full vector, 1=broadcast wd3, 2=single lane, 3=reserved (no write)
wmask  in  VECTOR_SIZE  per-lane write enable; bit i gates lane i
wlane  in  LANE_W  target lane for wmode=2
v1  in  IDX_W  read port 1 register index
v2  in  IDX_W  read port 2 register index
v3  in  IDX_W  write register index
wd3  in  WIDTH  scalar write data, used for wmode 1 and 2
wvec  in  VECTOR_SIZE*WIDTH  full-vector write data, lane i at bits [i*WIDTH +: WIDTH]
vd1  out  VECTOR_SIZE*WIDTH  read data port 1, same lane packing
vd2  out  VECTOR_SIZE*WIDTH  read data port 2, same lane packing

Behaviour:
- One clock, clk. rst is synchronous and active-high.
- Two-state FSM, IDLE and CLEAR, with clear pointer clr_ptr (IDX_W bits).
- rst=1 at a posedge: state<=CLEAR, clr_ptr<=1. busy reads 1 from the following cycle. Register contents are not reset directly.
- CLEAR: on each cycle, all lanes of register clr_ptr <= 0 and clr_ptr increments. When clr_ptr==NUM_VECTORES-1 has been cleared, state<=IDLE. The sweep therefore takes NUM_VECTORES-1 cycles and busy is 1 for exactly that many cycles.
- clr_req while IDLE: state<=CLEAR, clr_ptr<=1 on the next edge. clr_req while CLEAR is ignored; the sweep does not restart.
- rst asserted mid-sweep restarts the sweep at clr_ptr=1.
- busy = (state==CLEAR). While busy=1: vd1 and vd2 are all-zero, and we3 is ignored.
- Write in IDLE with we3=1 and v3!=0, committed at the posedge:
  - wmode 0: lane i <= wvec lane i, for every lane i with wmask[i]=1.
  - wmode 1: lane i <= wd3, for every lane i with wmask[i]=1.
  - wmode 2: lane wlane <= wd3, only if wmask[wlane]=1 and wlane<VECTOR_SIZE.
  - wmode 3: no write.
- v3==0 never writes. An all-zero wmask writes nothing.
- Simultaneous we3 and clr_req in IDLE: the write commits this cycle, then the sweep starts and zeroes the written register.
- Read ports are combinational. v1==0 or v2==0 returns all-zero on that port. Data written at edge N is visible on reads from edge N onward (write-then-read, 1-cycle latency).
- v1==v2 is legal; both ports return the same data.

Optional Feature:
- Macro VRF_WRITE_BYPASS_EN.
- Defined: when we3=1, not busy, v3!=0, and v1 (or v2) equals v3, the read port returns the merged value combinationally in the same cycle. Lanes being written (per wmode and wmask) take the new data; all other lanes take the stored data.
- Undefined: no forwarding; reads return stored contents only. Written data appears the cycle after the edge.

Decomposition:
- Package vrf_pkg holds: wmode_e enum (WM_VEC, WM_BCAST, WM_LANE, WM_RSVD), vrf_state_e enum (ST_IDLE, ST_CLEAR), and a function computing the per-lane write-enable vector from wmode, wmask and wlane.
- Sub-module vrf_read_port, instantiated twice. It handles the zero-register check, busy gating and the bypass merge; the bypass logic is compiled only under VRF_WRITE_BYPASS_EN.

Test Plan:
- Reset, then clear: pulse rst 1 cycle -> busy=1 for 15 cycles (defaults), then 0; v1=5 reads all-zero afterwards.
- Full-vector masked write: wmode=0, v3=3, wvec lane i=i+0x100, wmask=0x00FF -> v1=3 shows lanes 0-7 = 0x100-0x107, lanes 8-15 = 0.
- Broadcast and lane writes: wmode=1, v3=4, wd3=0xABCD, wmask=0xFFFF, then wmode=2, wlane=7, wd3=0x1234 -> v2=4 shows 0xABCD in all lanes except lane 7 = 0x1234.
- Zero register and reserved mode: we3 with v3=0, and separately wmode=3 on v3=6 -> v1=0 reads zero; register 6 is unchanged.
- Clear request racing a write: we3 to v3=2 together with clr_req -> busy for 15 cycles, reads zero during the sweep, register 2 reads zero afterwards; rst at sweep cycle 5 -> busy lasts 15 more cycles.
- Bypass: same-cycle write v3=v1=9, wmask=0x0001 -> with VRF_WRITE_BYPASS_EN, vd1 lane 0 = new data in the same cycle; without it, vd1 lane 0 shows old data until the next edge.
